// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with a registered read port and registered full/empty flags.
// Define FIFO_STATUS_EN to add the data_count, overflow and underflow status outputs.
module sync_byte_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
`ifdef FIFO_STATUS_EN
  ,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned PW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr_nxt;
  logic [PW-1:0]         rd_ptr_nxt;
  logic [PW-1:0]         count_nxt;
  logic                  wr_ok;
  logic                  rd_ok;

  // Accept qualification and post-edge occupancy; flags are registered from count_nxt.
  always_comb begin
    wr_ok      = wr_en & ~full;
    rd_ok      = rd_en & ~empty;
    wr_ptr_nxt = wr_ok ? wr_ptr + PW'(1) : wr_ptr;
    rd_ptr_nxt = rd_ok ? rd_ptr + PW'(1) : rd_ptr;
    count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      if (rd_ok) begin
        dout <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      end
      full  <= (count_nxt == PW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

`ifdef FIFO_STATUS_EN
  // Occupancy mirror plus one-cycle pulses for dropped requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_count <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      data_count <= count_nxt;
      overflow   <= wr_en & full;
      underflow  <= rd_en & empty;
    end
  end
`endif

endmodule

// File: tb/tb_sync_byte_fifo.sv
// Randomised and directed bench for sync_byte_fifo against a queue-based model.
// Build with FIFO_STATUS_EN defined to also check the status outputs.
module tb_sync_byte_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] din = '0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] dout;
  logic          full;
  logic          empty;
`ifdef FIFO_STATUS_EN
  logic [AW:0]   data_count;
  logic          overflow;
  logic          underflow;
  logic          m_ovf;
  logic          m_udf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;

  sync_byte_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .dout       (dout),
    .full       (full),
    .empty      (empty)
`ifdef FIFO_STATUS_EN
    ,
    .data_count (data_count),
    .overflow   (overflow),
    .underflow  (underflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a plain queue, with accept decisions taken from the pre-edge occupancy.
  always @(posedge clk or posedge rst) begin
    int sz;
    logic w_ok;
    logic r_ok;
    if (rst) begin
      q.delete();
      m_dout = '0;
`ifdef FIFO_STATUS_EN
      m_ovf = 1'b0;
      m_udf = 1'b0;
`endif
    end else begin
      sz   = q.size();
      w_ok = wr_en && (sz < DEPTH);
      r_ok = rd_en && (sz > 0);
`ifdef FIFO_STATUS_EN
      m_ovf = wr_en && (sz == DEPTH);
      m_udf = rd_en && (sz == 0);
`endif
      if (r_ok) m_dout = q.pop_front();
      if (w_ok) q.push_back(din);
    end
  end

  // Cycle-by-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    chk("dout",  32'(dout),  32'(m_dout));
    chk("full",  32'(full),  32'(q.size() == DEPTH));
    chk("empty", 32'(empty), 32'(q.size() == 0));
`ifdef FIFO_STATUS_EN
    chk("data_count", 32'(data_count), 32'(q.size()));
    chk("overflow",   32'(overflow),   32'(m_ovf));
    chk("underflow",  32'(underflow),  32'(m_udf));
`endif
  end

  task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
    @(negedge clk);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pw;
    int pr;
    #50;
    chk("rst_dout",  32'(dout),  32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    #50;
    rst = 1'b0;

    // First write: empty falls, dout untouched.
    step(1'b1, 1'b0, 8'd10);
    chk("w1_empty", 32'(empty), 32'd0);
    chk("w1_full",  32'(full),  32'd0);
    chk("w1_dout",  32'(dout),  32'd0);
    step(1'b1, 1'b0, 8'd7);
    step(1'b1, 1'b0, 8'd7);
`ifdef FIFO_STATUS_EN
    chk("cnt3", 32'(data_count), 32'd3);
`endif
    step(1'b0, 1'b1, 8'd0);
    chk("rd1_dout", 32'(dout), 32'd10);
    step(1'b0, 1'b1, 8'd0);
    chk("rd2_dout",  32'(dout),  32'd7);
    chk("rd2_empty", 32'(empty), 32'd0);
    step(1'b0, 1'b1, 8'd0);
    chk("rd3_dout",  32'(dout),  32'd7);
    chk("rd3_empty", 32'(empty), 32'd1);
    step(1'b0, 1'b1, 8'd0);
    chk("rd4_dout", 32'(dout), 32'd7);
`ifdef FIFO_STATUS_EN
    chk("rd4_underflow", 32'(underflow), 32'd1);
`endif
    step(1'b0, 1'b0, 8'd0);

    // Fill past capacity: the 17th write is dropped.
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 1'b0, DW'(i));
      if (i == 15) chk("fill_full16", 32'(full), 32'd1);
      if (i == 14) chk("fill_full15", 32'(full), 32'd0);
    end
    chk("fill_full17", 32'(full), 32'd1);
`ifdef FIFO_STATUS_EN
    chk("fill_overflow", 32'(overflow), 32'd1);
`endif
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'd0);
      chk("drain_dout", 32'(dout), 32'(i));
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // Half fill, then streaming with simultaneous read/write across the wrap.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, DW'(100 + i));
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b1, DW'(200 + k));
      chk("stream_dout", 32'(dout), (k < 8) ? 32'(100 + k) : 32'(200 + k - 8));
      chk("stream_empty", 32'(empty), 32'd0);
`ifdef FIFO_STATUS_EN
      chk("stream_cnt", 32'(data_count), 32'd8);
`endif
    end

    // Asynchronous reset mid-stream takes effect before the next clock edge.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_full",  32'(full),  32'd0);
    chk("arst_dout",  32'(dout),  32'd0);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2;
    rst = 1'b0;
    step(1'b0, 1'b1, 8'd0);
    chk("post_rst_empty", 32'(empty), 32'd1);
    chk("post_rst_dout",  32'(dout),  32'd0);

    // Random traffic, alternating write-heavy and read-heavy phases.
    for (int i = 0; i < 800; i++) begin
      pw = ((i / 100) % 2 == 0) ? 80 : 30;
      pr = ((i / 100) % 2 == 0) ? 30 : 80;
      step(1'($urandom_range(99) < 32'(pw)), 1'($urandom_range(99) < 32'(pr)), DW'($urandom));
      if (i == 450) begin
        #1;
        rst = 1'b1;
        #1;
        chk("rnd_arst_empty", 32'(empty), 32'd1);
        #1;
        rst = 1'b0;
      end
    end
    step(1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sync_byte_fifo.md
Name: sync_byte_fifo

Overview:
- Single-clock synchronous FIFO buffering data words between a producer and a consumer in the same clock domain.
- Write and read are independent per-cycle enables, qualified internally by full and empty.
- Registered (non-first-word-fall-through) read data port.
- Used as a general byte queue, e.g. between a host-interface byte stream and downstream logic.

Parameters:
- DATA_WIDTH, 8, width of din/dout in bits.
- ADDR_WIDTH, 4, log2 of depth; depth = 2**ADDR_WIDTH = 16 entries.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous, active-high reset.
- din  input  DATA_WIDTH  write data, sampled on clk rise when a write is accepted.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- dout  output  DATA_WIDTH  registered read data.
- full  output  1  high when the FIFO holds 2**ADDR_WIDTH entries.
- empty  output  1  high when the FIFO holds 0 entries.

Interface rule (already decided): one clock; reset is asynchronous and active-high (ports clk and rst).

Behaviour:
- Reset (rst=1, asynchronous):
  - Write pointer, read pointer and occupancy are cleared to 0.
  - Outputs: dout=0, empty=1, full=0.
  - Memory contents are not reset.
- Storage:
  - Memory array has 2**ADDR_WIDTH entries.
  - Read and write pointers are ADDR_WIDTH+1 bits; the extra MSB disambiguates full from empty.
  - The address field wraps modulo depth.
- Write accept (wr_ok) = wr_en & ~full.
  - On clk rise: mem[wr_ptr] <= din, wr_ptr increments.
  - A write while full is dropped silently; no state changes.
- Read accept (rd_ok) = rd_en & ~empty.
  - On clk rise: dout <= mem[rd_ptr], rd_ptr increments.
  - Read latency is 1 cycle: data is valid on dout after the edge that samples rd_en.
  - A read while empty is dropped; dout holds its previous value.
- dout holds its value on every cycle without an accepted read.
- Simultaneous wr_en and rd_en, neither full nor empty: both are accepted in the same cycle and occupancy is unchanged.
- Simultaneous wr_en and rd_en while empty: only the write is accepted. The new word is not forwarded to dout that cycle.
- Simultaneous wr_en and rd_en while full: only the read is accepted; the write is dropped.
- Flags:
  - full and empty are registered and reflect occupancy after each edge, with no combinational path from wr_en/rd_en.
  - Occupancy transitions: empty deasserts the cycle after the first accepted write; full asserts the cycle after the write that makes occupancy 16.
- Reset mid-operation: all queued data is discarded at once; the next read after release sees empty=1.

Optional Feature:
- Macro: FIFO_STATUS_EN.
- When defined, three extra outputs are added:
  - data_count [ADDR_WIDTH:0]: current occupancy, 0..16, registered.
  - overflow (1 bit): pulses high for one cycle after a write attempted while full.
  - underflow (1 bit): pulses high for one cycle after a read attempted while empty.
  - All three reset to 0.
- When undefined, these ports and their logic do not exist; core behaviour is identical in both cases.

Test Plan:
- Release rst after 100 ns, write 10 for one cycle -> empty falls to 0 after that edge; full stays 0; dout stays 0.
- Write 7 with wr_en held two cycles -> occupancy 3, queue holds 10, 7, 7.
- Hold rd_en two cycles -> dout=10 after the first edge, dout=7 after the second; empty remains 0.
- Hold rd_en two more cycles -> dout=7 after the first edge, then empty=1. The second read is ignored and dout holds 7; with FIFO_STATUS_EN, underflow pulses once.
- Write 0x00..0x10 (17 writes) -> full=1 after the 16th write, the 17th is dropped (overflow pulses if enabled). Sixteen reads return 0x00..0x0F, after which empty=1.
- Fill with 8 words, then hold wr_en and rd_en together for 20 cycles with an incrementing din -> occupancy stays 8 and pointers wrap. Data returns in order; asserting rst mid-stream gives empty=1, full=0, dout=0 immediately, without waiting for a clock edge.
